maze_update_rx: RTL
===================

MAZE_UPDATE_RX -- requirements
Module: maze_update_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 25000, the number of CLOCK cycles with no synchronized strobe edge, while the frame is high, that aborts a packet; legal range 2..65535.
REQ-002 Port: CLOCK  input  1  25 MHz system clock; all state is updated on the rising edge.
REQ-003 Port: RESET  input  1  the block has one clock; reset is asynchronous and active-high.
REQ-004 Port: SFRAME_IN  input  1  packet frame from the robot controller; asynchronous to CLOCK; high for the duration of a packet.
REQ-005 Port: SCLK_IN  input  1  bit strobe; asynchronous to CLOCK; data is sampled on its rising edge.
REQ-006 Port: SDATA_IN  input  1  serial data, MSB first; asynchronous to CLOCK.
REQ-007 Port: CLR_ERR  input  1  synchronous clear of ERR_COUNT and ERR_CODE.
REQ-008 Port: WR_EN  output  1  one-cycle grid-cell write strobe.
REQ-009 Port: WR_ROW  output  2  grid row (0-3).
REQ-010 Port: WR_COL  output  3  grid column (0-4).
REQ-011 Port: WR_DATA  output  2  cell state (0 = black, 1 = blue, 2 = green, 3 = red).
REQ-012 Port: BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-013 Port: PKT_COUNT  output  8  count of accepted packets.
REQ-014 Port: ERR_COUNT  output  8  count of rejected packets.
REQ-015 Port: ERR_CODE  output  3  code of the last error (0 = none, 1 = parity, 2 = range, 3 = short, 4 = long, 5 = timeout).

Function
REQ-016 SFRAME_IN, SCLK_IN and SDATA_IN shall each pass through a 2-flop synchronizer; the FSM shall use only the synchronized values (s_frame, s_clk, s_data).
REQ-017 A strobe edge is the cycle in which s_clk is 1 and the previous s_clk was 0; s_data shall be shifted in during that same cycle.
REQ-018 Packet format, MSB first: row[1:0], col[2:0], state[1:0], parity; the parity bit makes the total number of 1s in the 8 bits even.
REQ-019 FSM states: DRAIN, IDLE, SHIFT, CHECK, WRITE.
REQ-020 DRAIN -> IDLE when s_frame = 0.
REQ-021 IDLE -> SHIFT when s_frame = 1; on entry to SHIFT, the bit count and the timeout counter shall be cleared.
REQ-022 SHIFT: each strobe edge shifts in one bit, increments a saturating 4-bit bit count and clears the timeout counter.
REQ-023 SHIFT: a strobe edge after the 8th bit sets a long flag; the shift register is left unchanged.
REQ-024 SHIFT -> CHECK when s_frame = 0; a strobe edge in the same cycle as the frame fall shall be ignored.
REQ-025 SHIFT -> DRAIN when the timeout counter reaches TIMEOUT_CYCLES - 1 while s_frame = 1; this records error 5.
REQ-026 CHECK, error priority: long (4) > short, fewer than 8 bits (3) > parity (1) > range, row > 3 or col > 4 (2).
REQ-027 CHECK on any error: record the error and go to IDLE; otherwise go to WRITE.
REQ-028 WRITE: WR_EN = 1 for exactly one cycle, with WR_ROW/WR_COL/WR_DATA valid in that cycle; PKT_COUNT increments; then go to IDLE.
REQ-029 WR_EN shall be high in the 2nd cycle after the first cycle in which s_frame is observed 0 in SHIFT.
REQ-030 WR_ROW, WR_COL and WR_DATA shall hold their values until the next accepted packet.
REQ-031 Recording an error: ERR_CODE takes the new code; ERR_COUNT increments and saturates at 255.
REQ-032 PKT_COUNT wraps from 255 to 0.
REQ-033 CLR_ERR clears ERR_COUNT and ERR_CODE to 0; if an error is recorded in the same cycle, the clear wins and that error is discarded.
REQ-034 A frame that rises during CHECK or WRITE shall be entered from IDLE on the next cycle; any bits it strobed earlier are lost, which yields error 3.

Reset
REQ-035 While RESET = 1: state = DRAIN; WR_EN, WR_ROW, WR_COL, WR_DATA, PKT_COUNT, ERR_COUNT, ERR_CODE, the shift register, the counters and the synchronizer flops = 0; BUSY = 1.
REQ-036 Reset asserted mid-packet shall abort the packet with no write and no error; after reset release, no packet is accepted until SFRAME_IN has been seen low.

Verification
REQ-037 Frame with bits 0xA6 (row 2, col 4, state 3, parity 0) -> exactly one WR_EN pulse with WR_ROW = 2, WR_COL = 4, WR_DATA = 3 at the REQ-029 cycle; PKT_COUNT = 1.
REQ-038 Frame with bits 0xA7 -> no WR_EN; ERR_CODE = 1; ERR_COUNT = 1. Frame with bits 0x2B (col 5) -> ERR_CODE = 2; ERR_COUNT = 2.
REQ-039 Frame with 5 strobes -> ERR_CODE = 3; frame with 9 strobes -> ERR_CODE = 4; no WR_EN in either case; then pulse CLR_ERR -> ERR_COUNT = 0 and ERR_CODE = 0.
REQ-040 TIMEOUT_CYCLES = 100, frame high with 3 strobes then idle -> ERR_CODE = 5 after 100 quiet cycles; BUSY stays 1 until SFRAME_IN falls.
REQ-041 Assert RESET after 4 bits, release with SFRAME_IN still high, then send 0xA6 after the frame falls -> no write for the aborted packet; one write (2, 4, 3) for 0xA6.
REQ-042 Send 256 valid packets back-to-back with 2 idle cycles between frames -> 256 WR_EN pulses; PKT_COUNT = 0 after wrap.

Source files
------------

// File: rtl/maze_update_rx.sv
// Serial grid-cell update receiver: synchronizes the robot controller's frame/strobe/data
// lines, assembles 8-bit packets, validates them and issues single-cycle cell writes.
module maze_update_rx #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SFRAME_IN,
  input  logic       SCLK_IN,
  input  logic       SDATA_IN,
  input  logic       CLR_ERR,
  output logic       WR_EN,
  output logic [1:0] WR_ROW,
  output logic [2:0] WR_COL,
  output logic [1:0] WR_DATA,
  output logic       BUSY,
  output logic [7:0] PKT_COUNT,
  output logic [7:0] ERR_COUNT,
  output logic [2:0] ERR_CODE
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {ST_DRAIN, ST_IDLE, ST_SHIFT, ST_CHECK, ST_WRITE} state_t;

  state_t     state_reg;
  logic [2:0] meta_reg, sync_reg;
  logic       clk_prev_reg;
  logic [1:0] prime_reg;
  logic [7:0] shift_reg;
  logic [3:0] bit_cnt_reg;
  logic [15:0] tmo_reg;
  logic       long_reg;
  logic       wr_en_reg;
  logic [1:0] wr_row_reg, wr_data_reg;
  logic [2:0] wr_col_reg;
  logic [7:0] pkt_count_reg, err_count_reg;
  logic [2:0] err_code_reg;

  logic       s_frame, s_clk, s_data, strobe;
  logic [2:0] check_code, rec_code;
  logic       timeout_hit, rec_err;

  assign s_frame = sync_reg[0];
  assign s_clk   = sync_reg[1];
  assign s_data  = sync_reg[2];

  // prime_reg keeps DRAIN from trusting s_frame until the synchronizer holds real samples.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      meta_reg     <= '0;
      sync_reg     <= '0;
      clk_prev_reg <= 1'b0;
      prime_reg    <= '0;
    end else begin
      meta_reg     <= {SDATA_IN, SCLK_IN, SFRAME_IN};
      sync_reg     <= meta_reg;
      clk_prev_reg <= s_clk;
      prime_reg    <= {prime_reg[0], 1'b1};
    end
  end

  always_comb begin
    strobe = s_clk & ~clk_prev_reg;
    if (long_reg)                   check_code = 3'd4;
    else if (bit_cnt_reg < 4'd8)    check_code = 3'd3;
    else if (^shift_reg)            check_code = 3'd1;
    else if (shift_reg[5:3] > 3'd4) check_code = 3'd2;
    else                            check_code = 3'd0;
    timeout_hit = (state_reg == ST_SHIFT) && s_frame && !strobe && (tmo_reg == TMO_LAST);
    rec_err  = 1'b0;
    rec_code = 3'd0;
    if (timeout_hit) begin
      rec_err  = 1'b1;
      rec_code = 3'd5;
    end else if (state_reg == ST_CHECK && check_code != 3'd0) begin
      rec_err  = 1'b1;
      rec_code = check_code;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= ST_DRAIN;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      tmo_reg       <= '0;
      long_reg      <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_row_reg    <= '0;
      wr_col_reg    <= '0;
      wr_data_reg   <= '0;
      pkt_count_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        ST_DRAIN: if (!s_frame && prime_reg[1]) state_reg <= ST_IDLE;
        ST_IDLE: begin
          if (s_frame) begin
            state_reg   <= ST_SHIFT;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_reg     <= '0;
            long_reg    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // Frame fall takes precedence over a coincident strobe.
          if (!s_frame) begin
            state_reg <= ST_CHECK;
          end else if (strobe) begin
            tmo_reg <= '0;
            if (bit_cnt_reg < 4'd8) shift_reg <= {shift_reg[6:0], s_data};
            else                    long_reg  <= 1'b1;
            if (bit_cnt_reg != 4'hF) bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end else if (timeout_hit) begin
            state_reg <= ST_DRAIN;
          end else begin
            tmo_reg <= tmo_reg + 16'd1;
          end
        end
        ST_CHECK: begin
          if (check_code != 3'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg   <= ST_WRITE;
            wr_en_reg   <= 1'b1;
            wr_row_reg  <= shift_reg[7:6];
            wr_col_reg  <= shift_reg[5:3];
            wr_data_reg <= shift_reg[2:1];
          end
        end
        ST_WRITE: begin
          pkt_count_reg <= pkt_count_reg + 8'd1;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_DRAIN;
      endcase
    end
  end

  // A clear in the same cycle as a new error discards that error.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      err_code_reg  <= '0;
      err_count_reg <= '0;
    end else if (CLR_ERR) begin
      err_code_reg  <= '0;
      err_count_reg <= '0;
    end else if (rec_err) begin
      err_code_reg <= rec_code;
      if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign WR_EN     = wr_en_reg;
  assign WR_ROW    = wr_row_reg;
  assign WR_COL    = wr_col_reg;
  assign WR_DATA   = wr_data_reg;
  assign BUSY      = (state_reg != ST_IDLE);
  assign PKT_COUNT = pkt_count_reg;
  assign ERR_COUNT = err_count_reg;
  assign ERR_CODE  = err_code_reg;

endmodule
